cp0_regfile: RTL and testbench

- Architectural CP0 state holder; the writer side of the CP0 interface that decode reads through `cp0_nxt`.
- Commits MTC0 writes and exception entry/ERET from the memory stage.
- Runs the Count/Compare timer and latches external interrupts.
- Produces the pending-interrupt request and the redirect PC for exceptions and ERET.

---
 rtl/cp0_regfile_pkg.sv | 52 +++++
 rtl/cp0_regfile_if.sv | 34 +++
 rtl/cp0_regfile_timer.sv | 43 ++++
 rtl/cp0_regfile.sv | 127 ++++++++++++
 tb/tb_cp0_regfile.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_regfile_pkg.sv
// CP0 shared types: register numbers, Status/Cause bit positions, ExcCodes.
// Latency: n/a; backpressure: n/a.
package cp0_regfile_pkg;

  typedef struct packed {
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
  } cp0_t;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int ST_IM_HI  = 15;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  localparam int CA_EXC_LO = 2;
  localparam int CA_EXC_HI = 6;
  localparam int CA_IP_LO  = 8;
  localparam int CA_IP_HI  = 15;
  localparam int CA_SWIP_HI = 9;
  localparam int CA_HWIP_LO = 10;
  localparam int CA_HWIP_HI = 14;
  localparam int CA_IP7    = 15;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;

  // A delay-slot fault must restart at the branch that owns the slot.
  function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// Pipeline <-> CP0 bundle: MTC0/exception/ERET commit in, next-state view and redirect out.
// Latency: n/a; backpressure: none, every commit is accepted the cycle it is presented.
interface cp0_regfile_if;
  import cp0_regfile_pkg::*;

  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        exc_vaddr_v;
  logic [31:0] exc_vaddr;
  logic        eret;
  logic [5:0]  ext_int;
  cp0_t        cp0_nxt;
  logic        int_req;
  logic        redirect_v;
  logic [31:0] redirect_pc;

  modport master (
    output wen, waddr, wdata, exc_valid, exc_code, exc_pc, exc_bd,
           exc_vaddr_v, exc_vaddr, eret, ext_int,
    input  cp0_nxt, int_req, redirect_v, redirect_pc
  );

  modport slave (
    input  wen, waddr, wdata, exc_valid, exc_code, exc_pc, exc_bd,
           exc_vaddr_v, exc_vaddr, eret, ext_int,
    output cp0_nxt, int_req, redirect_v, redirect_pc
  );

endinterface

// File: rtl/cp0_regfile_timer.sv
// Count register with half-rate tick; flags a Count==Compare match on increment.
// Latency: count_nxt/ti_set combinational from state + inputs; backpressure: none.
module cp0_regfile_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_wen,
  input  logic [31:0] count_wdata,
  input  logic [31:0] compare_q,
  output logic [31:0] count_nxt,
  output logic        ti_set
);

  logic [31:0] count_q, count_d, count_inc;
  logic        tick_q, tick_d;

  always_comb begin
    count_inc = count_q + 32'd1;
    count_d   = count_q;
    tick_d    = ~tick_q;
    ti_set    = 1'b0;
    if (count_wen) begin
      // Software write realigns the tick phase.
      count_d = count_wdata;
      tick_d  = 1'b0;
    end else if (tick_q) begin
      count_d = count_inc;
      ti_set  = (count_inc == compare_q);
    end
  end

  assign count_nxt = count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 32'd0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// Architectural CP0 state: MTC0, exception entry and ERET commit; timer and interrupt request.
// Latency: cp0_nxt/redirect combinational, state on next edge; backpressure: none.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input logic         clk,
  input logic         reset,
  cp0_regfile_if.slave bus
);

  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] count_nxt;
  logic        ti_set;
  logic        ti_d;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic        exc_writes_epc;
  logic        unused_ext_int5;

  assign wr_count   = bus.wen && (bus.waddr == CP0_COUNT);
  assign wr_compare = bus.wen && (bus.waddr == CP0_COMPARE);
  assign wr_status  = bus.wen && (bus.waddr == CP0_STATUS);
  assign wr_cause   = bus.wen && (bus.waddr == CP0_CAUSE);
  assign wr_epc     = bus.wen && (bus.waddr == CP0_EPC);

  // A nested exception (EXL already set) keeps the original EPC and BD.
  assign exc_writes_epc = bus.exc_valid && !status_q[ST_EXL];

  // IP7 is the timer line, so HW5 has no Cause slot.
  assign unused_ext_int5 = bus.ext_int[5];

  cp0_regfile_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .count_wen   (wr_count),
    .count_wdata (bus.wdata),
    .compare_q   (compare_q),
    .count_nxt   (count_nxt),
    .ti_set      (ti_set)
  );

  always_comb begin
    badvaddr_d = badvaddr_q;
    if (bus.exc_valid && bus.exc_vaddr_v) begin
      badvaddr_d = bus.exc_vaddr;
    end

    compare_d = wr_compare ? bus.wdata : compare_q;

    status_d = status_q;
    if (wr_status) begin
      status_d = (status_q & ~STATUS_WMASK) | (bus.wdata & STATUS_WMASK);
    end
    if (bus.exc_valid) begin
      status_d[ST_EXL] = 1'b1;
    end else if (bus.eret) begin
      status_d[ST_EXL] = 1'b0;
    end

    epc_d = epc_q;
    if (exc_writes_epc) begin
      epc_d = epc_target(bus.exc_pc, bus.exc_bd);
    end else if (wr_epc) begin
      epc_d = bus.wdata;
    end

    // Compare write acknowledges the timer, even against a same-cycle match.
    ti_d = cause_q[CA_TI];
    if (wr_compare) begin
      ti_d = 1'b0;
    end else if (ti_set) begin
      ti_d = 1'b1;
    end

    cause_d = cause_q;
    cause_d[CA_TI]  = ti_d;
    cause_d[CA_IP7] = ti_d;
    cause_d[CA_HWIP_HI:CA_HWIP_LO] = bus.ext_int[4:0];
    if (wr_cause) begin
      cause_d[CA_SWIP_HI:CA_IP_LO] = bus.wdata[CA_SWIP_HI:CA_IP_LO];
    end
    if (bus.exc_valid) begin
      cause_d[CA_EXC_HI:CA_EXC_LO] = bus.exc_code;
    end
    if (exc_writes_epc) begin
      cause_d[CA_BD] = bus.exc_bd;
    end
  end

  assign bus.cp0_nxt = '{
    badvaddr: badvaddr_d,
    count:    count_nxt,
    compare:  compare_d,
    status:   status_d,
    cause:    cause_d,
    epc:      epc_d
  };

  assign bus.int_req = status_q[ST_IE] & ~status_q[ST_EXL]
                     & |(cause_q[CA_IP_HI:CA_IP_LO] & status_q[ST_IM_HI:ST_IM_LO]);

  assign bus.redirect_v  = bus.exc_valid | bus.eret;
  assign bus.redirect_pc = bus.exc_valid ? EXC_VECTOR : epc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      badvaddr_q <= 32'd0;
      compare_q  <= 32'd0;
      status_q   <= STATUS_RESET;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
    end else begin
      badvaddr_q <= badvaddr_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: expectations queued at drive time, popped at sampling.
module tb_cp0_regfile;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cp0_regfile_if bus();

  cp0_regfile #(
    .EXC_VECTOR   (32'hBFC0_0380),
    .STATUS_RESET (32'h0040_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic expect_v(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed %h required an entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wen         = 1'b0;
    bus.waddr       = 5'd0;
    bus.wdata       = 32'd0;
    bus.exc_valid   = 1'b0;
    bus.exc_code    = 5'd0;
    bus.exc_pc      = 32'd0;
    bus.exc_bd      = 1'b0;
    bus.exc_vaddr_v = 1'b0;
    bus.exc_vaddr   = 32'd0;
    bus.eret        = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    bus.wen   = 1'b1;
    bus.waddr = addr;
    bus.wdata = data;
  endtask

  task automatic raise_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                           input logic vv, input logic [31:0] va);
    bus.exc_valid   = 1'b1;
    bus.exc_code    = code;
    bus.exc_pc      = pc;
    bus.exc_bd      = bd;
    bus.exc_vaddr_v = vv;
    bus.exc_vaddr   = va;
  endtask

  initial begin
    int n;
    idle_inputs();
    bus.ext_int = 6'd0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    expect_v("rst_status", 32'h0040_0000);
    expect_v("rst_cause", 32'h0);
    expect_v("rst_epc", 32'h0);
    expect_v("rst_badvaddr", 32'h0);
    expect_v("rst_count", 32'h0);
    expect_v("rst_int_req", 32'h0);
    #1;
    check(bus.cp0_nxt.status);
    check(bus.cp0_nxt.cause);
    check(bus.cp0_nxt.epc);
    check(bus.cp0_nxt.badvaddr);
    check(bus.cp0_nxt.count);
    check(32'(bus.int_req));

    // Ten idle cycles: Count advances every other cycle
    repeat (10) step();
    expect_v("count_after_10", 32'd5);
    check(bus.cp0_nxt.count);
    step();
    expect_v("count_nxt_incr", 32'd6);
    check(bus.cp0_nxt.count);

    // MTC0 Status seen combinationally, then registered
    mtc0(5'd12, 32'h0000_FF01);
    expect_v("status_comb", 32'h0040_FF01);
    #1 check(bus.cp0_nxt.status);
    step();
    idle_inputs();
    expect_v("status_reg", 32'h0040_FF01);
    expect_v("int_req_no_ip", 32'h0);
    #1;
    check(bus.cp0_nxt.status);
    check(32'(bus.int_req));

    // Timer: Compare=20, wait for the match
    mtc0(5'd11, 32'd20);
    step();
    idle_inputs();
    n = 0;
    while (bus.int_req !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    expect_v("timer_int_req", 32'h1);
    expect_v("timer_count", 32'd20);
    expect_v("timer_cause", 32'h4000_8000);
    check(32'(bus.int_req));
    check(bus.cp0_nxt.count);
    check(bus.cp0_nxt.cause);

    // ext_int sampled into IP; Compare write clears TI in the same cycle
    bus.ext_int = 6'b100010;
    expect_v("cause_ext_int", 32'h4000_8800);
    #1 check(bus.cp0_nxt.cause);
    mtc0(5'd11, 32'hFFFF_0000);
    expect_v("cause_ti_clear", 32'h0000_0800);
    #1 check(bus.cp0_nxt.cause);
    step();
    idle_inputs();
    bus.ext_int = 6'd0;
    step();
    expect_v("int_req_cleared", 32'h0);
    check(32'(bus.int_req));

    // MTC0 Cause: only IP[1:0] writable
    mtc0(5'd13, 32'hFFFF_FFFF);
    expect_v("cause_sw_ip", 32'h0000_0300);
    #1 check(bus.cp0_nxt.cause);
    step();
    idle_inputs();
    expect_v("int_req_sw_ip", 32'h1);
    #1 check(32'(bus.int_req));
    mtc0(5'd13, 32'h0);
    step();
    idle_inputs();

    // Exception in a delay slot with EXL=0
    raise_exc(5'd8, 32'hBFC0_1004, 1'b1, 1'b0, 32'h0);
    expect_v("exc_redirect_v", 32'h1);
    expect_v("exc_redirect_pc", 32'hBFC0_0380);
    expect_v("exc_epc", 32'hBFC0_1000);
    expect_v("exc_cause", 32'h8000_0020);
    expect_v("exc_status", 32'h0040_FF03);
    #1;
    check(32'(bus.redirect_v));
    check(bus.redirect_pc);
    check(bus.cp0_nxt.epc);
    check(bus.cp0_nxt.cause);
    check(bus.cp0_nxt.status);
    step();
    idle_inputs();
    expect_v("exc_int_req_masked", 32'h0);
    expect_v("exc_redirect_idle", 32'h0);
    #1;
    check(32'(bus.int_req));
    check(32'(bus.redirect_v));

    // Nested exception leaves EPC and BD alone
    raise_exc(5'd12, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    expect_v("nested_epc", 32'hBFC0_1000);
    expect_v("nested_cause", 32'h8000_0030);
    #1;
    check(bus.cp0_nxt.epc);
    check(bus.cp0_nxt.cause);
    step();
    idle_inputs();

    // BadVAddr capture; MTC0 to it is ignored
    raise_exc(5'd4, 32'h0000_2000, 1'b0, 1'b1, 32'h8000_0003);
    expect_v("badvaddr_exc", 32'h8000_0003);
    #1 check(bus.cp0_nxt.badvaddr);
    step();
    idle_inputs();
    mtc0(5'd8, 32'hDEAD_BEEF);
    expect_v("badvaddr_ro", 32'h8000_0003);
    #1 check(bus.cp0_nxt.badvaddr);
    step();
    idle_inputs();

    // ERET with same-cycle MTC0 EPC: redirect uses old EPC
    bus.eret = 1'b1;
    mtc0(5'd14, 32'h0040_0100);
    expect_v("eret_redirect_pc", 32'hBFC0_1000);
    expect_v("eret_redirect_v", 32'h1);
    expect_v("eret_status", 32'h0040_FF01);
    expect_v("eret_epc_nxt", 32'h0040_0100);
    #1;
    check(bus.redirect_pc);
    check(32'(bus.redirect_v));
    check(bus.cp0_nxt.status);
    check(bus.cp0_nxt.epc);
    step();
    idle_inputs();
    expect_v("eret_epc_reg", 32'h0040_0100);
    expect_v("eret_redirect_pc_new", 32'h0040_0100);
    #1;
    check(bus.cp0_nxt.epc);
    bus.eret = 1'b1;
    #1 check(bus.redirect_pc);
    bus.eret = 1'b0;

    // Exception and ERET together: exception wins
    raise_exc(5'd10, 32'h0000_1000, 1'b0, 1'b0, 32'h0);
    bus.eret = 1'b1;
    expect_v("exc_eret_pc", 32'hBFC0_0380);
    expect_v("exc_eret_status", 32'h0040_FF03);
    expect_v("exc_eret_epc", 32'h0000_1000);
    #1;
    check(bus.redirect_pc);
    check(bus.cp0_nxt.status);
    check(bus.cp0_nxt.epc);
    step();
    idle_inputs();

    // Reset overrides a same-cycle exception
    reset = 1'b1;
    raise_exc(5'd13, 32'h0000_4444, 1'b1, 1'b1, 32'h1111_1111);
    step();
    reset = 1'b0;
    idle_inputs();
    expect_v("rst2_status", 32'h0040_0000);
    expect_v("rst2_epc", 32'h0);
    expect_v("rst2_cause", 32'h0);
    expect_v("rst2_badvaddr", 32'h0);
    expect_v("rst2_count", 32'h0);
    #1;
    check(bus.cp0_nxt.status);
    check(bus.cp0_nxt.epc);
    check(bus.cp0_nxt.cause);
    check(bus.cp0_nxt.badvaddr);
    check(bus.cp0_nxt.count);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
